// File: rtl/io_xbar_out_arb_pkg.sv
// Shared types and constants for the I/O crossbar output arbiter.
// State encoding and header length field position live here so every user agrees on them.
package io_xbar_out_arb_pkg;

  typedef enum logic {
    IO_XBAR_ARB_IDLE = 1'b0,
    IO_XBAR_ARB_PKT  = 1'b1
  } arb_state_e;

  localparam int IO_XBAR_LEN_LSB   = 22;
  localparam int IO_XBAR_LEN_WIDTH = 8;

endpackage

// File: rtl/io_xbar_credit_cnt.sv
// Credit counter for the downstream NIB; starts full, saturates on extra yummies.
// IO_XBAR_ARB_CREDIT_ERR_EN adds a sticky credit_err flag for overflowing yummies.
module io_xbar_credit_cnt #(
  parameter int BUFFER_SIZE = 4,
  parameter int BUFFER_BITS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic take,
  input  logic yummy,
  output logic credit_ok
`ifdef IO_XBAR_ARB_CREDIT_ERR_EN
  ,
  output logic credit_err
`endif
);

  localparam logic [BUFFER_BITS-1:0] FULL = BUFFER_BITS'(BUFFER_SIZE);

  logic [BUFFER_BITS-1:0] credits;

  // A transfer and a yummy in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= FULL;
    end else if (take && !yummy) begin
      credits <= credits - BUFFER_BITS'(1);
    end else if (yummy && !take && credits != FULL) begin
      credits <= credits + BUFFER_BITS'(1);
    end
  end

  assign credit_ok = (credits != '0);

`ifdef IO_XBAR_ARB_CREDIT_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_err <= 1'b0;
    end else if (yummy && !take && credits == FULL) begin
      credit_err <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/io_xbar_out_arb.sv
// Packet-granular round-robin arbiter sharing one credit-based crossbar output link.
// Define IO_XBAR_ARB_CREDIT_ERR_EN to expose the sticky credit_err output.
module io_xbar_out_arb
  import io_xbar_out_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int SRC_BITS    = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int BUFFER_SIZE = 4,
  parameter int BUFFER_BITS = 3,
  parameter int LEN_LSB     = IO_XBAR_LEN_LSB,
  parameter int LEN_WIDTH   = IO_XBAR_LEN_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_yummy,
  output logic [SRC_BITS-1:0]           grant_src,
  output logic                          busy
`ifdef IO_XBAR_ARB_CREDIT_ERR_EN
  ,
  output logic                          credit_err
`endif
);

  arb_state_e            state_q, state_d;
  logic [SRC_BITS-1:0]   rr_ptr_q, grant_q, pick, sel;
  logic                  pick_found, credit_ok, transfer;
  logic [LEN_WIDTH-1:0]  remaining_q, len;
  logic [DATA_WIDTH-1:0] sel_data;

  io_xbar_credit_cnt #(
    .BUFFER_SIZE (BUFFER_SIZE),
    .BUFFER_BITS (BUFFER_BITS)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .take       (transfer),
    .yummy      (out_yummy),
    .credit_ok  (credit_ok)
`ifdef IO_XBAR_ARB_CREDIT_ERR_EN
    ,
    .credit_err (credit_err)
`endif
  );

  // First valid source at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!pick_found && src_valid[idx]) begin
        pick       = SRC_BITS'(idx);
        pick_found = 1'b1;
      end
    end
  end

  assign sel      = (state_q == IO_XBAR_ARB_IDLE) ? pick : grant_q;
  assign sel_data = src_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign transfer = credit_ok && src_valid[sel];
  assign len      = sel_data[LEN_LSB +: LEN_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IO_XBAR_ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IO_XBAR_ARB_IDLE: if (transfer && len != '0) state_d = IO_XBAR_ARB_PKT;
      IO_XBAR_ARB_PKT:  if (transfer && remaining_q == LEN_WIDTH'(1)) state_d = IO_XBAR_ARB_IDLE;
      default:          state_d = IO_XBAR_ARB_IDLE;
    endcase
  end

  always_comb begin
    src_ready = '0;
    if (transfer) src_ready[sel] = 1'b1;
    busy = (state_q == IO_XBAR_ARB_PKT);
  end

  // Accepted flit is registered toward the NIB; out_data holds between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      remaining_q <= '0;
    end else begin
      out_valid <= transfer;
      if (transfer) begin
        out_data <= sel_data;
        if (state_q == IO_XBAR_ARB_IDLE) begin
          grant_q     <= pick;
          rr_ptr_q    <= (pick == SRC_BITS'(NUM_SRC - 1)) ? '0 : pick + SRC_BITS'(1);
          remaining_q <= len;
        end else begin
          remaining_q <= remaining_q - LEN_WIDTH'(1);
        end
      end
    end
  end

  assign grant_src = grant_q;

endmodule

// File: tb/tb_io_xbar_out_arb.sv
// Randomized self-checking bench for io_xbar_out_arb against a packet-level reference model.
// Also checks credit_err when built with IO_XBAR_ARB_CREDIT_ERR_EN.
module tb_io_xbar_out_arb;

  localparam int NS  = 4;
  localparam int DW  = 64;
  localparam int BUF = 4;

  logic            clk;
  logic            rst_n;
  logic [NS-1:0]   src_valid;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]   src_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_yummy;
  logic [1:0]      grant_src;
  logic            busy;
`ifdef IO_XBAR_ARB_CREDIT_ERR_EN
  logic            credit_err;
`endif

  io_xbar_out_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_yummy  (out_yummy),
    .grant_src  (grant_src),
    .busy       (busy)
`ifdef IO_XBAR_ARB_CREDIT_ERR_EN
    ,
    .credit_err (credit_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: packet owner (-1 when free), flits still owed, credits, rotation start.
  int          m_credits;
  int          m_owner;
  int          m_left;
  int          m_rr;
  int          m_grant;
  logic        m_valid;
  logic [DW-1:0] m_data;
  logic        m_err;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [DW-1:0] flit(input int len);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    d[22 +: 8] = 8'(len);
    return d;
  endfunction

  task automatic modelReset();
    m_credits = BUF;
    m_owner   = -1;
    m_left    = 0;
    m_rr      = 0;
    m_grant   = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_err     = 1'b0;
  endtask

  task automatic checkRegs();
    checkOutput("out_valid", 64'(out_valid), 64'(m_valid));
    checkOutput("out_data", out_data, m_data);
    checkOutput("grant_src", 64'(grant_src), 64'(m_grant));
    checkOutput("busy", 64'(busy), 64'(m_owner >= 0));
`ifdef IO_XBAR_ARB_CREDIT_ERR_EN
    checkOutput("credit_err", 64'(credit_err), 64'(m_err));
`endif
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear immediately.
  task automatic asyncReset();
    #2;
    rst_n     = 1'b0;
    src_valid = '0;
    out_yummy = 1'b0;
    #1;
    modelReset();
    checkRegs();
    checkOutput("src_ready_rst", 64'(src_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [NS-1:0] v, input logic [NS*DW-1:0] d, input logic y);
    int win;
    int idx;
    logic [DW-1:0] f;
    @(negedge clk);
    src_valid = v;
    src_data  = d;
    out_yummy = y;
    #1;
    win = -1;
    if (m_credits > 0) begin
      if (m_owner < 0) begin
        for (int k = 0; k < NS; k++) begin
          idx = (m_rr + k) % NS;
          if (win < 0 && v[idx]) win = idx;
        end
      end else if (v[m_owner]) begin
        win = m_owner;
      end
    end
    checkOutput("src_ready", 64'(src_ready), (win >= 0) ? (64'd1 << win) : 64'd0);
    @(posedge clk);
    if (win >= 0) begin
      f       = d[win*DW +: DW];
      m_valid = 1'b1;
      m_data  = f;
      if (!y) m_credits--;
      if (m_owner < 0) begin
        m_grant = win;
        m_rr    = (win + 1) % NS;
        if (f[22 +: 8] != 0) begin
          m_owner = win;
          m_left  = int'(f[22 +: 8]);
        end
      end else begin
        m_left--;
        if (m_left == 0) m_owner = -1;
      end
    end else begin
      m_valid = 1'b0;
      if (y) begin
        if (m_credits == BUF) m_err = 1'b1;
        else m_credits++;
      end
    end
    #1;
    checkRegs();
  endtask

  initial begin
    int rate;
    logic [NS-1:0] v;
    rst_n     = 1'b0;
    src_valid = '0;
    src_data  = '0;
    out_yummy = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkRegs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single len=0 header from source 0.
    applyStimulus(4'b0001, {flit(0), flit(0), flit(0), flit(0)}, 1'b0);
    applyStimulus(4'b0000, '0, 1'b1);

    // All sources valid with single-flit packets, credit returned every cycle.
    repeat (5) applyStimulus(4'b1111, {flit(0), flit(0), flit(0), flit(0)}, 1'b1);

    // Source 1 multi-flit packet while source 2 also waits.
    applyStimulus(4'b0000, '0, 1'b1);
    applyStimulus(4'b0010, {flit(0), flit(0), flit(3), flit(0)}, 1'b0);
    repeat (3) applyStimulus(4'b0110, {flit(0), flit(0), flit(1), flit(0)}, 1'b1);
    repeat (2) applyStimulus(4'b0100, {flit(0), flit(0), flit(0), flit(0)}, 1'b1);
    repeat (4) applyStimulus(4'b0000, '0, 1'b1);

    // Credit exhaustion, then a single returned credit; then overflowing yummies.
    repeat (6) applyStimulus(4'b0001, {flit(0), flit(0), flit(0), flit(0)}, 1'b0);
    applyStimulus(4'b0000, '0, 1'b1);
    repeat (3) applyStimulus(4'b0001, {flit(0), flit(0), flit(0), flit(0)}, 1'b0);
    applyStimulus(4'b0000, '0, 1'b1);
    applyStimulus(4'b0000, '0, 1'b1);
    repeat (2) applyStimulus(4'b0001, {flit(0), flit(0), flit(0), flit(0)}, 1'b1);
    repeat (6) applyStimulus(4'b0000, '0, 1'b1);

    // Randomized traffic with varying credit-return rates.
    for (int c = 0; c < 600; c++) begin
      rate = (c < 200) ? 85 : (c < 400) ? 30 : 100;
      v = NS'($urandom);
      applyStimulus(v, {flit($urandom_range(0, 3)), flit($urandom_range(0, 3)),
                        flit($urandom_range(0, 3)), flit($urandom_range(0, 3))},
                    ($urandom % 100) < rate);
    end

    // Asynchronous reset in the middle of a len=5 packet.
    asyncReset();
    applyStimulus(4'b0001, {flit(0), flit(0), flit(0), flit(5)}, 1'b0);
    applyStimulus(4'b0001, {flit(0), flit(0), flit(0), flit(0)}, 1'b0);
    asyncReset();
    repeat (5) applyStimulus(4'b0011, {flit(0), flit(0), flit(0), flit(0)}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
